// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : cook_timer
// Purpose  : BCD mm:ss countdown timer for the microwave oven, keypad loaded.
//            Optional macro TIMER_ADD30_EN adds a "+30 s" strobe input.
// Revision : 1.0 - initial release
// ============================================================================
module cook_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRESC_W       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clrn,
    input  logic       mag_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
`ifdef TIMER_ADD30_EN
    input  logic       add30,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    logic [3:0]         r_mt, r_mo, r_st, r_so;
    logic [PRESC_W-1:0] r_presc;
    logic               r_done;

    logic               w_zero, w_running, w_tick, w_key_ok;
    logic [3:0]         w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic [3:0]         w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;
    logic [PRESC_W-1:0] w_nxt_presc;

    assign w_zero    = ({r_mt, r_mo, r_st, r_so} == 16'd0);
    assign w_running = mag_on && !w_zero;
    assign w_tick    = w_running && (r_presc == C_PRESC_MAX);
    assign w_key_ok  = key_valid && !mag_on && (key_digit <= 4'd9);

    // One-second BCD decrement; only selected when the count is nonzero.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so;
        if (r_so != 4'd0) begin
            w_dec_so = r_so - 4'd1;
        end else if (r_st != 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 4'd1;
        end else begin
            w_dec_so = 4'd9;
            w_dec_st = 4'd5;
            if (r_mo != 4'd0) begin
                w_dec_mo = r_mo - 4'd1;
            end else begin
                w_dec_mo = 4'd9;
                w_dec_mt = r_mt - 4'd1;
            end
        end
    end

`ifdef TIMER_ADD30_EN
    logic [3:0] w_add_mt, w_add_mo, w_add_st, w_add_so;

    // +30 s with minute carry; a carry out of 99 saturates at 99:59.
    always_comb begin
        w_add_mt = r_mt;
        w_add_mo = r_mo;
        w_add_st = r_st;
        w_add_so = r_so;
        if (r_st >= 4'd3) begin
            w_add_st = r_st - 4'd3;
            if (r_mo != 4'd9) begin
                w_add_mo = r_mo + 4'd1;
            end else if (r_mt != 4'd9) begin
                w_add_mo = 4'd0;
                w_add_mt = r_mt + 4'd1;
            end else begin
                w_add_st = 4'd5;
                w_add_so = 4'd9;
            end
        end else begin
            w_add_st = r_st + 4'd3;
        end
    end
`endif

    always_comb begin
        w_nxt_mt    = r_mt;
        w_nxt_mo    = r_mo;
        w_nxt_st    = r_st;
        w_nxt_so    = r_so;
        w_nxt_presc = r_presc;
        if (w_running) begin
            w_nxt_presc = (r_presc == C_PRESC_MAX) ? '0 : r_presc + PRESC_W'(1);
        end
        if (!clrn) begin
            w_nxt_mt    = 4'd0;
            w_nxt_mo    = 4'd0;
            w_nxt_st    = 4'd0;
            w_nxt_so    = 4'd0;
            w_nxt_presc = '0;
`ifdef TIMER_ADD30_EN
        end else if (add30) begin
            // A coincident tick is dropped; the prescaler keeps running.
            w_nxt_mt = w_add_mt;
            w_nxt_mo = w_add_mo;
            w_nxt_st = w_add_st;
            w_nxt_so = w_add_so;
`endif
        end else if (w_tick) begin
            w_nxt_mt = w_dec_mt;
            w_nxt_mo = w_dec_mo;
            w_nxt_st = w_dec_st;
            w_nxt_so = w_dec_so;
        end else if (w_key_ok) begin
            w_nxt_mt    = r_mo;
            w_nxt_mo    = r_st;
            w_nxt_st    = r_so;
            w_nxt_so    = key_digit;
            w_nxt_presc = '0;
        end
    end

    // Done is derived from the next count so it moves on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
            r_presc <= '0;
            r_done  <= 1'b1;
        end else begin
            r_mt    <= w_nxt_mt;
            r_mo    <= w_nxt_mo;
            r_st    <= w_nxt_st;
            r_so    <= w_nxt_so;
            r_presc <= w_nxt_presc;
            r_done  <= ({w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so} == 16'd0);
        end
    end

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign timer_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cook_timer
// Purpose  : Self-checking bench for cook_timer; integer minutes/seconds model
//            plus directed literal checks. TIMER_ADD30_EN enables add30 tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cook_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrn = 1'b1;
    logic       mag_on = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       add30 = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;

    int n_cmp = 0;
    int n_err = 0;

    cook_timer #(.TICKS_PER_SEC(TPS), .PRESC_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .clrn       (clrn),
        .mag_on     (mag_on),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
`ifdef TIMER_ADD30_EN
        .add30      (add30),
`endif
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done)
    );

    always #5 clk = ~clk;

    // Model: minutes and seconds as plain integers (seconds field may be 60-99).
    int m_min = 0, m_sec = 0, m_p = 0;
    bit m_valid = 1'b0;

    function automatic logic [15:0] pack(input int mn, input int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    always @(posedge clk) begin
        bit running, tick, do_add;
        int v;
`ifdef TIMER_ADD30_EN
        do_add = add30;
`else
        do_add = 1'b0;
`endif
        if (rst) begin
            m_min = 0; m_sec = 0; m_p = 0; m_valid = 1'b1;
        end else if (!clrn) begin
            m_min = 0; m_sec = 0; m_p = 0;
        end else begin
            running = mag_on && (m_min != 0 || m_sec != 0);
            tick    = running && (m_p == TPS - 1);
            if (running) m_p = (m_p + 1) % TPS;
            if (do_add) begin
                if (m_sec >= 30) begin
                    m_sec -= 30;
                    m_min += 1;
                    if (m_min > 99) begin m_min = 99; m_sec = 59; end
                end else begin
                    m_sec += 30;
                end
            end else if (tick) begin
                if (m_sec > 0) m_sec -= 1;
                else begin m_sec = 59; m_min -= 1; end
            end else if (key_valid && !mag_on && key_digit <= 9) begin
                v = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
                m_min = v / 100;
                m_sec = v % 100;
                m_p = 0;
            end
        end
    end

    // Per-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if ({min_tens, min_ones, sec_tens, sec_ones} !== pack(m_min, m_sec) ||
                timer_done !== (m_min == 0 && m_sec == 0)) begin
                n_err++;
                $display("FAIL cycle_model t=%0t: got %h done=%b, model %h done=%b", $time,
                         {min_tens, min_ones, sec_tens, sec_ones}, timer_done,
                         pack(m_min, m_sec), (m_min == 0 && m_sec == 0));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic clear();
        clrn = 1'b0;
        step();
        clrn = 1'b1;
    endtask

    // Literal checks pin both the DUT and the model.
    task automatic chk(input string name, input logic [15:0] exp_d, input logic exp_done);
        n_cmp++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== exp_d || timer_done !== exp_done) begin
            n_err++;
            $display("FAIL %s: got %h done=%b, expected %h done=%b", name,
                     {min_tens, min_ones, sec_tens, sec_ones}, timer_done, exp_d, exp_done);
        end
        n_cmp++;
        if (pack(m_min, m_sec) !== exp_d) begin
            n_err++;
            $display("FAIL %s_model: model %h, expected %h", name, pack(m_min, m_sec), exp_d);
        end
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("reset", 16'h0000, 1'b1);
        press(4'd1); press(4'd3); press(4'd0);
        chk("keys_130", 16'h0130, 1'b0);

        // Countdown from 00:12
        clear();
        press(4'd1); press(4'd2);
        chk("load_12", 16'h0012, 1'b0);
        mag_on = 1'b1;
        step(3);
        chk("before_first_tick", 16'h0012, 1'b0);
        step(1);
        chk("tick1", 16'h0011, 1'b0);
        step(4);
        chk("tick2", 16'h0010, 1'b0);
        step(39);
        chk("one_left", 16'h0001, 1'b0);
        step(1);
        chk("reach_zero", 16'h0000, 1'b1);
        step(8);
        chk("hold_zero", 16'h0000, 1'b1);
        mag_on = 1'b0;

        // Borrow cases
        clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        mag_on = 1'b1;
        step(4);
        chk("borrow_1000", 16'h0959, 1'b0);
        mag_on = 1'b0;
        clear();
        press(4'd9); press(4'd0);
        chk("load_90", 16'h0090, 1'b0);
        mag_on = 1'b1;
        step(4);
        chk("borrow_90", 16'h0089, 1'b0);
        mag_on = 1'b0;

        // Pause/resume and ignored keys
        clear();
        press(4'd2); press(4'd0);
        mag_on = 1'b1;
        step(2);
        mag_on = 1'b0;
        step(10);
        chk("paused", 16'h0020, 1'b0);
        mag_on = 1'b1;
        press(4'd7);
        chk("key_while_on", 16'h0020, 1'b0);
        step(1);
        chk("resume_tick", 16'h0019, 1'b0);
        mag_on = 1'b0;
        press(4'd12);
        chk("key_over_9", 16'h0019, 1'b0);

        // Clear while running
        clear();
        press(4'd4); press(4'd5);
        mag_on = 1'b1;
        step(1);
        clear();
        chk("clear_running", 16'h0000, 1'b1);
        step(8);
        chk("clear_hold", 16'h0000, 1'b1);
        mag_on = 1'b0;

`ifdef TIMER_ADD30_EN
        clear();
        press(4'd4); press(4'd5);
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add_45", 16'h0115, 1'b0);
        clear();
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add_zero", 16'h0030, 1'b0);
        clear();
        press(4'd9); press(4'd9); press(4'd4); press(4'd0);
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add_sat", 16'h9959, 1'b0);
        clear();
        press(4'd3); press(4'd0);
        mag_on = 1'b1;
        step(3);
        add30 = 1'b1; step(); add30 = 1'b0;
        chk("add_vs_tick", 16'h0100, 1'b0);
        step(4);
        chk("after_add_tick", 16'h0059, 1'b0);
        mag_on = 1'b0;
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
